// File: rtl/renode_ahb_manager_core.sv
// AHB-Lite manager engine: turns a valid/ready request stream into single NONSEQ transfers.
// Define RENODE_AHB_MANAGER_PIPELINE_EN to overlap the next address phase with the current data phase.
module renode_ahb_manager_core #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_NONSEQ = 2'b10
    } htrans_e;

    // Address slot (A): its fields drive HADDR/HWRITE/HSIZE directly.
    logic                  a_valid_q, a_valid_d;
    logic [ADDR_WIDTH-1:0] a_addr_q,  a_addr_d;
    logic                  a_write_q, a_write_d;
    logic [2:0]            a_size_q,  a_size_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    htrans_e               htrans_q,  htrans_d;

    // Data slot (D) and response registers.
    logic                  d_valid_q, d_valid_d;
    logic                  d_write_q, d_write_d;
    logic [DATA_WIDTH-1:0] hwdata_q,  hwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    logic a_done;
    logic d_done;
    logic ready_raw;
    logic accept;

    assign a_done = a_valid_q && (htrans_q == HT_NONSEQ) && HREADY && !HRESP;
    assign d_done = d_valid_q && HREADY;

`ifdef RENODE_AHB_MANAGER_PIPELINE_EN
    logic d_err_first;
    assign d_err_first = d_valid_q && HRESP && !HREADY;
    assign ready_raw   = (!a_valid_q || a_done) && !d_err_first;
`else
    assign ready_raw   = !a_valid_q && (!d_valid_q || HREADY);
`endif

    assign req_ready = HRESETn && ready_raw;
    assign accept    = req_valid && req_ready;

    always_comb begin
        a_valid_d = a_valid_q;
        a_addr_d  = a_addr_q;
        a_write_d = a_write_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        if (a_done) begin
            a_valid_d = 1'b0;
        end
        if (accept) begin
            a_valid_d = 1'b1;
            a_addr_d  = req_addr;
            a_write_d = req_write;
            a_size_d  = req_size;
            a_wdata_d = req_wdata;
        end

        // A pending slot stays on the bus until taken; a first ERROR cycle in D
        // pulls it to IDLE for one cycle and it is re-presented afterwards.
        htrans_d = a_valid_d ? HT_NONSEQ : HT_IDLE;
`ifdef RENODE_AHB_MANAGER_PIPELINE_EN
        if (d_err_first) begin
            htrans_d = HT_IDLE;
        end
`endif

        d_valid_d = d_valid_q;
        d_write_d = d_write_q;
        hwdata_d  = hwdata_q;
        if (d_done) begin
            d_valid_d = 1'b0;
        end
        if (a_done) begin
            d_valid_d = 1'b1;
            d_write_d = a_write_q;
            hwdata_d  = a_wdata_q;
        end

        rsp_valid_d = d_done;
        rsp_rdata_d = (d_done && !d_write_q) ? HRDATA : '0;
        rsp_error_d = d_done && HRESP;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_q   <= 1'b0;
            a_addr_q    <= '0;
            a_write_q   <= 1'b0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            htrans_q    <= HT_IDLE;
            d_valid_q   <= 1'b0;
            d_write_q   <= 1'b0;
            hwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_addr_q    <= a_addr_d;
            a_write_q   <= a_write_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            htrans_q    <= htrans_d;
            d_valid_q   <= d_valid_d;
            d_write_q   <= d_write_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign HADDR     = a_addr_q;
    assign HWRITE    = a_write_q;
    assign HSIZE     = a_size_q;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_renode_ahb_manager_core.sv
// Scoreboard bench for renode_ahb_manager_core: a behavioural AHB-Lite subordinate answers the
// bus from its own memory while a reference memory model predicts every response in request order.
module tb_renode_ahb_manager_core;

`ifdef RENODE_AHB_MANAGER_PIPELINE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr  = '0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size  = 3'd2;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP  = 1'b0;

    renode_ahb_manager_core #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Environment: error region and default memory contents.
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    function automatic logic is_err(input logic [31:0] a);
        return (a[15:12] == 4'hE) || (a == err_addr);
    endfunction
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Reference model: memory updated in request order at acceptance.
    logic [31:0] ref_mem [logic [31:0]];
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int unsigned acc;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: pops one expectation per response pulse.
    exp_t        mon_e;
    int unsigned rsp_edges[$];
    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            rsp_edges.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                check("rsp_error", 64'(rsp_error), 64'(mon_e.err));
                if (mon_e.lat >= 0)
                    check("rsp_latency", 64'((cyc + 1) - mon_e.acc), 64'(mon_e.lat));
            end
        end
    end

    // Behavioural subordinate, evaluated once per cycle on the falling edge.
    logic [31:0] bus_mem [logic [31:0]];
    int unsigned fixed_wait = 0;
    int unsigned max_wait   = 0;
    logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0, dp_first = 1'b0;
    logic [31:0] dp_addr = '0, dp_hwdata = '0;
    int unsigned dp_wait = 0, err_stage = 0;
    logic        p_hready = 1'b1, p_hresp = 1'b0, p_hwrite = 1'b0;
    logic [1:0]  p_htrans = 2'b00;
    logic [31:0] p_haddr = '0;
    logic        trace_en = 1'b0;
    logic        ns_trace[$];

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_valid = 1'b0;
            p_hready = 1'b1; p_hresp = 1'b0; p_htrans = 2'b00;
            HREADY   = 1'b1; HRESP   = 1'b0; HRDATA   = '0;
        end else begin
            if (p_hready) begin
                dp_valid = 1'b0;
                if (p_htrans == 2'b10) begin
                    dp_valid  = 1'b1;
                    dp_addr   = p_haddr;
                    dp_write  = p_hwrite;
                    dp_err    = is_err(p_haddr);
                    dp_wait   = (max_wait == 0) ? fixed_wait : $urandom_range(max_wait, 0);
                    err_stage = 0;
                    dp_first  = 1'b1;
                end
            end
            if (!p_hready && !p_hresp && p_htrans == 2'b10) begin
                check("htrans_stable", 64'(HTRANS), 64'(2'b10));
                check("haddr_stable", 64'(HADDR), 64'(p_haddr));
            end
            HRDATA = $urandom;
            HRESP  = 1'b0;
            HREADY = 1'b1;
            if (dp_valid) begin
                if (dp_write) begin
                    if (dp_first) dp_hwdata = HWDATA;
                    else check("hwdata_stable", 64'(HWDATA), 64'(dp_hwdata));
                end
                dp_first = 1'b0;
                if (dp_wait > 0) begin
                    HREADY = 1'b0;
                    dp_wait--;
                end else if (dp_err) begin
                    HRESP  = 1'b1;
                    HRDATA = '0;
                    if (err_stage == 0) begin
                        HREADY    = 1'b0;
                        err_stage = 1;
                    end else begin
                        check("htrans_idle_err2", 64'(HTRANS), 64'(2'b00));
                    end
                end else if (dp_write) begin
                    bus_mem[dp_addr] = HWDATA;
                end else begin
                    HRDATA = bus_mem.exists(dp_addr) ? bus_mem[dp_addr] : init_word(dp_addr);
                end
            end
            if (HTRANS == 2'b10 && HREADY) begin
                check("hsize", 64'(HSIZE), 64'd2);
                check("hctrl_const", 64'({HBURST, HPROT, HMASTLOCK}), 64'({3'b000, 4'b0011, 1'b0}));
            end
            if (trace_en) ns_trace.push_back(HTRANS == 2'b10);
            p_hready = HREADY; p_hresp = HRESP; p_htrans = HTRANS;
            p_haddr  = HADDR;  p_hwrite = HWRITE;
        end
    end

    // Called 1 time unit after a falling edge; returns at the same phase.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input int lat);
        exp_t        e;
        int unsigned waited = 0;
        req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = 3'd2; req_wdata = wdata;
        #2;
        while (!req_ready) begin
            if (waited >= 100) begin
                check("req_ready_timeout", 64'd0, 64'd1);
                req_valid = 1'b0;
                return;
            end
            waited++;
            @(negedge HCLK); #3;
        end
        e.err = is_err(addr);
        if (wr) begin
            e.rdata = '0;
            if (!e.err) ref_mem[addr] = wdata;
        end else begin
            e.rdata = e.err ? 32'h0 : (ref_mem.exists(addr) ? ref_mem[addr] : init_word(addr));
        end
        e.lat = lat;
        e.acc = cyc + 1;
        sb_q.push_back(e);
        @(negedge HCLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge HCLK);
            n++;
        end
        #1;
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
        repeat (2) @(negedge HCLK);
        #1;
    endtask

    task automatic trace_stats(output int cnt, output int span, output int maxrun);
        int first = -1, last = -1, run = 0;
        cnt = 0; maxrun = 0;
        foreach (ns_trace[i]) begin
            if (ns_trace[i]) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        span = (first < 0) ? 0 : last - first + 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        check({tag, "_haddr"}, 64'(HADDR), 64'd0);
        check({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        check({tag, "_hsize"}, 64'(HSIZE), 64'd0);
        check({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        check({tag, "_rsp_error"}, 64'(rsp_error), 64'd0);
    endtask

    initial begin
        int cnt, span, maxrun;
        logic [31:0] a;

        bus_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;

        repeat (3) @(negedge HCLK);
        #1;
        check_reset_outputs("reset");
        HRESETn = 1'b1;
        #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);
        @(negedge HCLK); #1;

        // Idle: nothing requested, nothing happens.
        repeat (8) begin
            check("idle_htrans", 64'(HTRANS), 64'd0);
            check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
            check("idle_req_ready", 64'(req_ready), 64'd1);
            @(negedge HCLK); #1;
        end

        // Single zero-wait read.
        ns_trace.delete(); trace_en = 1'b1;
        issue(32'h100, 1'b0, 32'h0, 3);
        drain();
        trace_en = 1'b0;
        trace_stats(cnt, span, maxrun);
        check("single_read_nonseq_cycles", 64'(cnt), 64'd1);

        // Write with two wait states, then read it back.
        fixed_wait = 2;
        issue(32'h300, 1'b1, 32'h1234_5678, 5);
        drain();
        fixed_wait = 0;
        issue(32'h300, 1'b0, 32'h0, 3);
        drain();

        // Back-to-back writes.
        ns_trace.delete(); rsp_edges.delete(); trace_en = 1'b1;
        for (int unsigned i = 0; i < 4; i++) issue(32'(4 * i), 1'b1, 32'hA000_0000 + 32'(i), -1);
        drain();
        trace_en = 1'b0;
        trace_stats(cnt, span, maxrun);
        check("b2b_nonseq_count", 64'(cnt), 64'd4);
        check("b2b_nonseq_span", 64'(span), PIPE ? 64'd4 : 64'd7);
        check("b2b_nonseq_maxrun", 64'(maxrun), PIPE ? 64'd4 : 64'd1);
        check("b2b_rsp_count", 64'(rsp_edges.size()), 64'd4);
        for (int i = 1; i < rsp_edges.size(); i++)
            check("b2b_rsp_gap", 64'(rsp_edges[i] - rsp_edges[i-1]), PIPE ? 64'd1 : 64'd2);

        // Two-cycle ERROR on a read with a write queued behind it.
        err_addr = 32'h40;
        ns_trace.delete(); trace_en = 1'b1;
        issue(32'h40, 1'b0, 32'h0, -1);
        issue(32'h44, 1'b1, 32'hCAFE_0044, -1);
        drain();
        trace_en = 1'b0;
        err_addr = 32'hFFFF_FFFF;
        trace_stats(cnt, span, maxrun);
        check("err_nonseq_cycles", 64'(cnt), PIPE ? 64'd3 : 64'd2);
        issue(32'h44, 1'b0, 32'h0, 3);
        drain();

        // Reset during a stalled data phase.
        fixed_wait = 6;
        issue(32'h500, 1'b0, 32'h0, -1);
        repeat (2) @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_q.delete();
        fixed_wait = 0;
        repeat (2) @(negedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK); #1;
        issue(32'h200, 1'b0, 32'h0, 3);
        drain();

        // Randomized traffic with random wait states and error regions.
        max_wait = 2;
        for (int unsigned n = 0; n < 150; n++) begin
            a = (($urandom_range(9, 0) == 0) ? 32'hE000 : 32'h1000) + 32'(4 * $urandom_range(7, 0));
            issue(a, 1'($urandom_range(1, 0)), $urandom, -1);
            repeat ($urandom_range(2, 0)) begin
                @(negedge HCLK); #1;
            end
        end
        drain();
        max_wait = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
